// File: rtl/dtw_path_backtrack_if.sv
// Column-load and step-stream handshake bundle for the DTW path backtracker.
// The slave modport is the backtracker; the master modport is its environment.
interface dtw_path_backtrack_if #(
    parameter int unsigned ROWS = 32,
    parameter int unsigned IW   = 5
);
    logic              col_valid;
    logic              col_ready;
    logic [2*ROWS-1:0] col_data;
    logic              step_valid;
    logic              step_ready;
    logic [IW-1:0]     step_i;
    logic [IW-1:0]     step_j;
    logic              step_last;

    modport master (
        output col_valid, col_data, step_ready,
        input  col_ready, step_valid, step_i, step_j, step_last
    );

    modport slave (
        input  col_valid, col_data, step_ready,
        output col_ready, step_valid, step_i, step_j, step_last
    );
endinterface

// File: rtl/dtw_path_backtrack.sv
// Captures a grid of 2-bit DTW predecessor codes column by column, then walks the
// optimal warping path from the far corner back to (0,0) as a ready/valid step stream.
module dtw_path_backtrack #(
    parameter int unsigned ROWS = 32,
    parameter int unsigned COLS = 32,
    parameter int unsigned IW   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [IW:0]          len_i,
    input  logic [IW:0]          len_j,
    dtw_path_backtrack_if.slave  bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [IW+1:0]        path_len
);

    typedef enum logic [1:0] {StIdle, StLoad, StTrace, StDone} state_e;

    localparam logic [IW:0] RowsMax = (IW+1)'(ROWS);
    localparam logic [IW:0] ColsMax = (IW+1)'(COLS);

    state_e        state_q, state_d;
    logic [IW:0]   len_i_q, len_i_d;
    logic [IW:0]   len_j_q, len_j_d;
    logic [IW-1:0] col_cnt_q, col_cnt_d;
    logic [IW-1:0] cur_i_q, cur_i_d;
    logic [IW-1:0] cur_j_q, cur_j_d;
    logic          err_q, err_d;
    logic [IW+1:0] path_len_q, path_len_d;

    // Storage is indexed [column][row]; no reset since contents are rewritten per job.
    logic [1:0]    mem_q [COLS][ROWS];
    logic [1:0]    code_cur;
    logic          col_we;
    logic          at_origin;

    assign code_cur  = mem_q[cur_j_q][cur_i_q];
    assign at_origin = (cur_i_q == '0) && (cur_j_q == '0);

    assign bus.col_ready  = (state_q == StLoad);
    assign bus.step_valid = (state_q == StTrace);
    assign bus.step_i     = cur_i_q;
    assign bus.step_j     = cur_j_q;
    assign bus.step_last  = (state_q == StTrace) && at_origin;
    assign busy           = (state_q != StIdle);
    assign done           = (state_q == StDone);
    assign err            = err_q;
    assign path_len       = path_len_q;

    always_comb begin
        state_d    = state_q;
        len_i_d    = len_i_q;
        len_j_d    = len_j_q;
        col_cnt_d  = col_cnt_q;
        cur_i_d    = cur_i_q;
        cur_j_d    = cur_j_q;
        err_d      = err_q;
        path_len_d = path_len_q;
        col_we     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_i_d    = len_i;
                    len_j_d    = len_j;
                    err_d      = 1'b0;
                    path_len_d = '0;
                    col_cnt_d  = '0;
                    if ((len_i == '0) || (len_j == '0) || (len_i > RowsMax) ||
                        (len_j > ColsMax)) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end

            StLoad: begin
                if (bus.col_valid) begin
                    col_we    = 1'b1;
                    col_cnt_d = col_cnt_q + 1'b1;
                    if ({1'b0, col_cnt_q} == (len_j_q - 1'b1)) begin
                        cur_i_d = IW'(len_i_q - 1'b1);
                        cur_j_d = IW'(len_j_q - 1'b1);
                        state_d = StTrace;
                    end
                end
            end

            StTrace: begin
                if (bus.step_ready) begin
                    path_len_d = path_len_q + 1'b1;
                    if (at_origin) begin
                        state_d = StDone;
                    end else if (cur_i_q == '0) begin
                        cur_j_d = cur_j_q - 1'b1;
                    end else if (cur_j_q == '0) begin
                        cur_i_d = cur_i_q - 1'b1;
                    end else begin
                        case (code_cur)
                            2'b11: begin
                                cur_i_d = cur_i_q - 1'b1;
                                cur_j_d = cur_j_q - 1'b1;
                            end
                            2'b10:   cur_i_d = cur_i_q - 1'b1;
                            2'b01:   cur_j_d = cur_j_q - 1'b1;
                            default: begin
                                err_d   = 1'b1;
                                state_d = StDone;
                            end
                        endcase
                    end
                end
            end

            StDone:  state_d = StIdle;

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            len_i_q    <= '0;
            len_j_q    <= '0;
            col_cnt_q  <= '0;
            cur_i_q    <= '0;
            cur_j_q    <= '0;
            err_q      <= 1'b0;
            path_len_q <= '0;
        end else begin
            state_q    <= state_d;
            len_i_q    <= len_i_d;
            len_j_q    <= len_j_d;
            col_cnt_q  <= col_cnt_d;
            cur_i_q    <= cur_i_d;
            cur_j_q    <= cur_j_d;
            err_q      <= err_d;
            path_len_q <= path_len_d;
        end
    end

    always_ff @(posedge clk) begin
        if (col_we) begin
            for (int r = 0; r < ROWS; r++) begin
                mem_q[col_cnt_q][r] <= bus.col_data[2*r +: 2];
            end
        end
    end

endmodule

// File: tb/tb_dtw_path_backtrack.sv
// Directed bench for dtw_path_backtrack: hand-derived warping paths, backpressure,
// error jobs and a mid-trace reset.
module tb_dtw_path_backtrack;
    localparam int unsigned ROWS = 32;
    localparam int unsigned COLS = 32;
    localparam int unsigned IW   = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [IW:0]   len_i;
    logic [IW:0]   len_j;
    logic          busy;
    logic          done;
    logic          err;
    logic [IW+1:0] path_len;

    dtw_path_backtrack_if #(.ROWS(ROWS), .IW(IW)) bus ();

    dtw_path_backtrack #(.ROWS(ROWS), .COLS(COLS), .IW(IW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len_i    (len_i),
        .len_j    (len_j),
        .bus      (bus.slave),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .path_len (path_len)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] grid [COLS][ROWS];
    int exp_i [8];
    int exp_j [8];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [1:0] code);
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                grid[c][r] = code;
    endtask

    task automatic start_job(input int li, input int lj);
        start = 1'b1;
        len_i = (IW+1)'(li);
        len_j = (IW+1)'(lj);
        tick();
        start = 1'b0;
    endtask

    task automatic send_cols(input int lj);
        logic [2*ROWS-1:0] v;
        bus.col_valid = 1'b1;
        for (int c = 0; c < lj; c++) begin
            for (int r = 0; r < ROWS; r++) v[2*r +: 2] = grid[c][r];
            bus.col_data = v;
            check_eq("col_ready", 32'(bus.col_ready), 1);
            tick();
        end
        bus.col_valid = 1'b0;
    endtask

    // Walks the step stream, checking each handshake against exp_i/exp_j and that
    // outputs hold during stalls; returns the cycle count until done.
    task automatic run_trace(input int n_exp, input logic [15:0] rdy_pat, input int pat_len,
                             output int cycles);
        int n = 0;
        int cyc = 0;
        logic stalled = 1'b0;
        logic [IW-1:0] si = '0;
        logic [IW-1:0] sj = '0;
        while (done !== 1'b1 && cyc < 40) begin
            bus.step_ready = (cyc < pat_len) ? rdy_pat[cyc] : 1'b1;
            if (stalled) begin
                check_eq("hold_i", 32'(bus.step_i), 32'(si));
                check_eq("hold_j", 32'(bus.step_j), 32'(sj));
            end
            stalled = 1'b0;
            if (bus.step_valid) begin
                if (bus.step_ready) begin
                    if (n < n_exp) begin
                        check_eq("step_i", 32'(bus.step_i), exp_i[n]);
                        check_eq("step_j", 32'(bus.step_j), exp_j[n]);
                        check_eq("step_last", 32'(bus.step_last),
                                 (exp_i[n] == 0 && exp_j[n] == 0) ? 1 : 0);
                    end
                    n++;
                end else begin
                    stalled = 1'b1;
                    si = bus.step_i;
                    sj = bus.step_j;
                end
            end
            tick();
            cyc++;
        end
        bus.step_ready = 1'b0;
        check_eq("handshakes", n, n_exp);
        check_eq("done_pulse", 32'(done), 1);
        cycles = cyc;
    endtask

    task automatic finish_job(input int exp_len, input int exp_err);
        check_eq("path_len", 32'(path_len), exp_len);
        check_eq("err", 32'(err), exp_err);
        tick();
        check_eq("done_clear", 32'(done), 0);
        check_eq("idle", 32'(busy), 0);
        check_eq("path_len_held", 32'(path_len), exp_len);
    endtask

    task automatic set_diag_exp();
        exp_i = '{3, 2, 1, 0, 0, 0, 0, 0};
        exp_j = '{3, 2, 1, 0, 0, 0, 0, 0};
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        start = 1'b0;
        len_i = '0;
        len_j = '0;
        bus.col_valid = 1'b0;
        bus.col_data = '0;
        bus.step_ready = 1'b0;
        tick();
        tick();
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_step_valid", 32'(bus.step_valid), 0);
        check_eq("rst_col_ready", 32'(bus.col_ready), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_err", 32'(err), 0);
        check_eq("rst_path_len", 32'(path_len), 0);
        rst = 1'b0;
        tick();

        // Zero row length: straight to DONE with err, never offers col_ready.
        start_job(0, 4);
        check_eq("len0_done", 32'(done), 1);
        check_eq("len0_err", 32'(err), 1);
        check_eq("len0_col_ready", 32'(bus.col_ready), 0);
        finish_job(0, 1);

        // Column length one past the maximum.
        start_job(4, 33);
        check_eq("len_j33_done", 32'(done), 1);
        finish_job(0, 1);

        // Diagonal 4x4; accepted start must clear the sticky err.
        fill(2'b11);
        start_job(4, 4);
        check_eq("diag_err_cleared", 32'(err), 0);
        check_eq("diag_busy", 32'(busy), 1);
        send_cols(4);
        check_eq("diag_first_valid", 32'(bus.step_valid), 1);
        set_diag_exp();
        run_trace(4, 16'hFFFF, 16, cyc);
        check_eq("diag_cycles", cyc, 4);
        finish_job(4, 0);

        // Single row: codes must be ignored on i==0.
        fill(2'b10);
        start_job(1, 4);
        send_cols(4);
        exp_i = '{0, 0, 0, 0, 0, 0, 0, 0};
        exp_j = '{3, 2, 1, 0, 0, 0, 0, 0};
        run_trace(4, 16'hFFFF, 16, cyc);
        finish_job(4, 0);

        // Mixed path 3x3: up, left, diagonal.
        fill(2'b00);
        grid[2][2] = 2'b10;
        grid[2][1] = 2'b01;
        grid[1][1] = 2'b11;
        start_job(3, 3);
        send_cols(3);
        exp_i = '{2, 1, 1, 0, 0, 0, 0, 0};
        exp_j = '{2, 2, 1, 0, 0, 0, 0, 0};
        run_trace(4, 16'hFFFF, 16, cyc);
        finish_job(4, 0);

        // Diagonal under backpressure 1,0,0,1,0,1,1.
        fill(2'b11);
        start_job(4, 4);
        send_cols(4);
        set_diag_exp();
        run_trace(4, 16'h0069, 7, cyc);
        check_eq("bp_cycles", cyc, 7);
        finish_job(4, 0);

        // Interior invalid code at the start corner.
        fill(2'b00);
        start_job(3, 3);
        send_cols(3);
        exp_i = '{2, 0, 0, 0, 0, 0, 0, 0};
        exp_j = '{2, 0, 0, 0, 0, 0, 0, 0};
        run_trace(1, 16'hFFFF, 16, cyc);
        finish_job(1, 1);

        // Reset after two accepted steps aborts without a done pulse.
        fill(2'b11);
        start_job(4, 4);
        send_cols(4);
        bus.step_ready = 1'b1;
        tick();
        tick();
        check_eq("mid_path_len", 32'(path_len), 2);
        rst = 1'b1;
        bus.step_ready = 1'b0;
        tick();
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_step_valid", 32'(bus.step_valid), 0);
        check_eq("abort_path_len", 32'(path_len), 0);
        check_eq("abort_done", 32'(done), 0);
        rst = 1'b0;
        tick();
        check_eq("abort_no_done", 32'(done), 0);

        start_job(4, 4);
        send_cols(4);
        set_diag_exp();
        run_trace(4, 16'hFFFF, 16, cyc);
        finish_job(4, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
